// File: rtl/rvfi_trace_buffer_pkg.sv
// Retirement trace record types shared by the trace buffer, its FIFO and the bus interface.
// One record per retired instruction; the entry adds the 64-bit order stamp.
package trace_pkg;

    localparam int XLEN = 32;

    typedef struct packed {
        logic [31:0]     insn;
        logic            trap;
        logic            halt;
        logic            intr;
        logic [1:0]      mode;
        logic [1:0]      ixl;
        logic [4:0]      rs1_addr;
        logic [4:0]      rs2_addr;
        logic [XLEN-1:0] rs1_rdata;
        logic [XLEN-1:0] rs2_rdata;
        logic [4:0]      rd_addr;
        logic [XLEN-1:0] rd_wdata;
        logic [XLEN-1:0] pc_rdata;
        logic [XLEN-1:0] pc_wdata;
        logic [XLEN-1:0] mem_addr;
        logic [3:0]      mem_rmask;
        logic [3:0]      mem_wmask;
        logic [XLEN-1:0] mem_rdata;
        logic [XLEN-1:0] mem_wdata;
    } trace_rec_t;

    typedef struct packed {
        logic [63:0] order;
        trace_rec_t  rec;
    } trace_ent_t;

endpackage

// File: rtl/rvfi_trace_buffer_if.sv
// Retire-lane input and valid/ready drain port of the trace buffer.
// master = retire stage plus consumer (bench), slave = trace buffer.
interface rvfi_trace_buffer_if
    import trace_pkg::*;
#(
    parameter int NRET = 1
) ();

    logic [NRET-1:0]        in_valid;
    trace_rec_t [NRET-1:0]  in_rec;
    logic                   out_valid;
    logic                   out_ready;
    trace_rec_t             out_rec;
    logic [63:0]            out_order;

    modport master (
        output in_valid, in_rec, out_ready,
        input  out_valid, out_rec, out_order
    );

    modport slave (
        input  in_valid, in_rec, out_ready,
        output out_valid, out_rec, out_order
    );

endinterface

// File: rtl/rvfi_trace_buffer_fifo_mwr.sv
// Trace entry storage: NRET write ports landing on consecutive addresses from wr_ptr,
// one asynchronous read port. Occupancy is tracked by the owner, not here.
module trace_fifo_mwr
    import trace_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int NRET  = 1,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                   clk,
    input  logic [AW-1:0]          wr_ptr,
    input  logic [NRET-1:0]        wr_en,
    input  trace_ent_t [NRET-1:0]  wr_ent,
    input  logic [AW-1:0]          rd_ptr,
    output trace_ent_t             rd_ent
);

    trace_ent_t mem_q [DEPTH];
    trace_ent_t mem_d [DEPTH];

    always_comb begin
        mem_d = mem_q;
        for (int s = 0; s < NRET; s++) begin
            if (wr_en[s]) begin
                mem_d[wr_ptr + AW'(s)] = wr_ent[s];
            end
        end
    end

    // Payload storage needs no reset; validity comes from the owner's level.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign rd_ent = mem_q[rd_ptr];

endmodule

// File: rtl/rvfi_trace_buffer.sv
// Multi-lane retirement trace buffer: ranks valid lanes, stamps order numbers,
// buffers entries and drains them one per cycle, with drop accounting and halt freeze.
module rvfi_trace_buffer
    import trace_pkg::*;
#(
    parameter int NRET   = 1,
    parameter int DEPTH  = 16,
    parameter int DROP_W = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    rvfi_trace_buffer_if.slave          bus,
    output logic [$clog2(DEPTH+1)-1:0]  level,
    output logic [DROP_W-1:0]           drop_cnt,
    output logic                        overflow,
    output logic                        halted
);

    localparam int LW = $clog2(DEPTH + 1);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    if (NRET < 1 || NRET > 4 || DEPTH < NRET || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_cfg
        $error("rvfi_trace_buffer: NRET must be 1..4, DEPTH a power of two >= NRET");
    end

    logic [LW-1:0]      level_q, level_d;
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [63:0]        ord_q, ord_d;
    logic [DROP_W-1:0]  drop_q, drop_d;
    logic               ovf_q, ovf_d;
    logic               halted_q, halted_d;

    logic [LW-1:0]      free;
    logic [LW-1:0]      n_rank, n_wr, n_drop;
    logic [LW-1:0]      lane_rank [NRET];
    logic [NRET-1:0]    lane_keep;
    logic               blocked, halt_hit;
    logic [NRET-1:0]    wr_en;
    trace_ent_t [NRET-1:0] wr_ent;
    trace_ent_t         rd_ent;
    logic               out_valid, pop;
    logic [DROP_W:0]    drop_sum;

    // Space is judged against the level at cycle start; a same-cycle pop frees nothing.
    assign free      = LW'(DEPTH) - level_q;
    assign out_valid = (level_q != '0);
    assign pop       = out_valid && bus.out_ready;

    // Rank lanes in ascending index; once a halt lane is ranked, later lanes are invisible.
    always_comb begin
        blocked   = halted_q;
        halt_hit  = 1'b0;
        n_rank    = '0;
        n_wr      = '0;
        n_drop    = '0;
        lane_keep = '0;
        for (int i = 0; i < NRET; i++) begin
            lane_rank[i] = n_rank;
            if (bus.in_valid[i] && !blocked) begin
                if (n_rank < free) begin
                    lane_keep[i] = 1'b1;
                    n_wr = n_wr + LW'(1);
                end else begin
                    n_drop = n_drop + LW'(1);
                end
                if (bus.in_rec[i].halt) begin
                    blocked  = 1'b1;
                    halt_hit = 1'b1;
                end
                n_rank = n_rank + LW'(1);
            end
        end
    end

    // Kept lanes always hold ranks 0..n_wr-1, so rank doubles as the write slot.
    always_comb begin
        wr_en  = '0;
        wr_ent = '0;
        for (int s = 0; s < NRET; s++) begin
            for (int i = 0; i < NRET; i++) begin
                if (lane_keep[i] && lane_rank[i] == LW'(s)) begin
                    wr_en[s]        = 1'b1;
                    wr_ent[s].order = ord_q + 64'(lane_rank[i]);
                    wr_ent[s].rec   = bus.in_rec[i];
                end
            end
        end
    end

    always_comb begin
        level_d  = level_q + n_wr - LW'(pop);
        wr_ptr_d = wr_ptr_q + AW'(n_wr);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        ord_d    = ord_q + 64'(n_rank);
        drop_sum = {1'b0, drop_q} + (DROP_W + 1)'(n_drop);
        drop_d   = drop_sum[DROP_W] ? '1 : drop_sum[DROP_W-1:0];
        ovf_d    = ovf_q | (n_drop != '0);
        halted_d = halted_q | halt_hit;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ord_q    <= '0;
            drop_q   <= '0;
            ovf_q    <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            level_q  <= level_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ord_q    <= ord_d;
            drop_q   <= drop_d;
            ovf_q    <= ovf_d;
            halted_q <= halted_d;
        end
    end

    trace_fifo_mwr #(
        .DEPTH (DEPTH),
        .NRET  (NRET),
        .AW    (AW)
    ) u_fifo (
        .clk    (clk),
        .wr_ptr (wr_ptr_q),
        .wr_en  (wr_en),
        .wr_ent (wr_ent),
        .rd_ptr (rd_ptr_q),
        .rd_ent (rd_ent)
    );

    // Head is forced to zero when empty so stale storage never leaks out.
    assign bus.out_valid = out_valid;
    assign bus.out_rec   = out_valid ? rd_ent.rec : '0;
    assign bus.out_order = out_valid ? rd_ent.order : 64'd0;

    assign level    = level_q;
    assign drop_cnt = drop_q;
    assign overflow = ovf_q;
    assign halted   = halted_q;

endmodule

// File: tb/tb_rvfi_trace_buffer.sv
// Scoreboard bench for rvfi_trace_buffer: three instances (1-lane/16, 2-lane/16, 2-lane/4 with 2-bit drop counter).
module tb_rvfi_trace_buffer;
    import trace_pkg::*;

    logic clk = 1'b0;
    logic rst_a = 1'b1, rst_b = 1'b1, rst_c = 1'b1;
    always #5 clk = ~clk;

    rvfi_trace_buffer_if #(.NRET(1)) ifa();
    rvfi_trace_buffer_if #(.NRET(2)) ifb();
    rvfi_trace_buffer_if #(.NRET(2)) ifc();

    logic [4:0]  level_a, level_b;
    logic [2:0]  level_c;
    logic [15:0] drop_a, drop_b;
    logic [1:0]  drop_c;
    logic        ovf_a, ovf_b, ovf_c;
    logic        halt_a, halt_b, halt_c;

    rvfi_trace_buffer #(.NRET(1), .DEPTH(16), .DROP_W(16)) u_a (
        .clk(clk), .rst(rst_a), .bus(ifa), .level(level_a), .drop_cnt(drop_a),
        .overflow(ovf_a), .halted(halt_a));
    rvfi_trace_buffer #(.NRET(2), .DEPTH(16), .DROP_W(16)) u_b (
        .clk(clk), .rst(rst_b), .bus(ifb), .level(level_b), .drop_cnt(drop_b),
        .overflow(ovf_b), .halted(halt_b));
    rvfi_trace_buffer #(.NRET(2), .DEPTH(4), .DROP_W(2)) u_c (
        .clk(clk), .rst(rst_c), .bus(ifc), .level(level_c), .drop_cnt(drop_c),
        .overflow(ovf_c), .halted(halt_c));

    typedef struct {
        logic [63:0] ord;
        logic [31:0] insn;
    } exp_t;

    exp_t exp_q [3][$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   max_lvl_a = 0;
    int   pop_cyc_a [$];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic trace_rec_t mk(input int id, input logic h);
        trace_rec_t r;
        r          = '0;
        r.insn     = 32'hA000_0000 | 32'(id);
        r.halt     = h;
        r.pc_rdata = 32'(id * 4);
        r.pc_wdata = 32'(id * 4 + 4);
        r.rd_addr  = 5'(id);
        return r;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic expect_rec(input int ch, input logic [63:0] ord, input int id);
        exp_t e;
        e.ord  = ord;
        e.insn = 32'hA000_0000 | 32'(id);
        exp_q[ch].push_back(e);
    endtask

    task automatic sb_pop(input int ch, input logic [63:0] ord, input logic [31:0] insn);
        exp_t e;
        if (exp_q[ch].size() == 0) begin
            total++;
            bad++;
            $display("FAIL sb_unexpected ch%0d: got order=%0d with nothing expected", ch, ord);
        end else begin
            e = exp_q[ch].pop_front();
            chk($sformatf("sb_order ch%0d", ch), ord, e.ord);
            chk($sformatf("sb_insn ch%0d", ch), 64'(insn), 64'(e.insn));
        end
    endtask

    // Monitor: compares every accepted head against the scoreboard.
    always @(negedge clk) begin
        if (!rst_a && ifa.out_valid && ifa.out_ready) begin
            sb_pop(0, ifa.out_order, ifa.out_rec.insn);
            pop_cyc_a.push_back(cyc);
        end
        if (!rst_b && ifb.out_valid && ifb.out_ready) sb_pop(1, ifb.out_order, ifb.out_rec.insn);
        if (!rst_c && ifc.out_valid && ifc.out_ready) sb_pop(2, ifc.out_order, ifc.out_rec.insn);
        if (!rst_a && int'(level_a) > max_lvl_a) max_lvl_a = int'(level_a);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int get_level(input int ch);
        if (ch == 0) return int'(level_a);
        if (ch == 1) return int'(level_b);
        return int'(level_c);
    endfunction

    task automatic wait_empty(input int ch, input int budget);
        int n = 0;
        while (get_level(ch) != 0 && n < budget) begin
            step();
            n++;
        end
        chk($sformatf("drain_to_empty ch%0d", ch), 64'(get_level(ch)), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        ifa.in_valid = '0; ifa.in_rec = '0; ifa.out_ready = 1'b0;
        ifb.in_valid = '0; ifb.in_rec = '0; ifb.out_ready = 1'b0;
        ifc.in_valid = '0; ifc.in_rec = '0; ifc.out_ready = 1'b0;
        step();
        step();
        chk("rst_a_out_valid", 64'(ifa.out_valid), 64'd0);
        chk("rst_a_level", 64'(level_a), 64'd0);
        chk("rst_a_drop", 64'(drop_a), 64'd0);
        chk("rst_a_overflow", 64'(ovf_a), 64'd0);
        chk("rst_a_halted", 64'(halt_a), 64'd0);
        chk("rst_a_out_order", ifa.out_order, 64'd0);
        chk("rst_b_level", 64'(level_b), 64'd0);
        chk("rst_c_drop", 64'(drop_c), 64'd0);
        chk("rst_c_halted", 64'(halt_c), 64'd0);
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        step();

        // Single lane, consumer always ready
        ifa.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ifa.in_valid = 1'b1;
            ifa.in_rec[0] = mk(1 + i, 1'b0);
            expect_rec(0, 64'(i), 1 + i);
            step();
        end
        ifa.in_valid = '0;
        wait_empty(0, 20);
        chk("a_level_peak", 64'(max_lvl_a), 64'd1);
        chk("a_pop_count", 64'(pop_cyc_a.size()), 64'd3);
        if (pop_cyc_a.size() == 3) begin
            chk("a_pop_gap01", 64'(pop_cyc_a[1] - pop_cyc_a[0]), 64'd1);
            chk("a_pop_gap12", 64'(pop_cyc_a[2] - pop_cyc_a[1]), 64'd1);
        end

        // Two lanes, no consumer: even orders on lane0, odd on lane1
        for (int c = 0; c < 4; c++) begin
            ifb.in_valid = 2'b11;
            ifb.in_rec[0] = mk(20 + 2 * c, 1'b0);
            ifb.in_rec[1] = mk(21 + 2 * c, 1'b0);
            expect_rec(1, 64'(2 * c), 20 + 2 * c);
            expect_rec(1, 64'(2 * c + 1), 21 + 2 * c);
            step();
        end
        ifb.in_valid = '0;
        chk("b_level_8", 64'(level_b), 64'd8);
        ifb.out_ready = 1'b1;
        wait_empty(1, 30);
        ifb.out_ready = 1'b0;

        // Backpressure: head must hold still while not accepted
        ifb.in_valid = 2'b01;
        ifb.in_rec[0] = mk(30, 1'b0);
        expect_rec(1, 64'd8, 30);
        step();
        ifb.in_valid = '0;
        for (int k = 0; k < 5; k++) begin
            chk("bp_valid", 64'(ifb.out_valid), 64'd1);
            chk("bp_order", ifb.out_order, 64'd8);
            chk("bp_insn", 64'(ifb.out_rec.insn), 64'hA000_001E);
            step();
        end
        ifb.out_ready = 1'b1;
        wait_empty(1, 10);
        ifb.out_ready = 1'b0;

        // Halt on lane0 with lane1 also valid
        ifb.in_valid = 2'b11;
        ifb.in_rec[0] = mk(60, 1'b1);
        ifb.in_rec[1] = mk(61, 1'b0);
        expect_rec(1, 64'd9, 60);
        step();
        chk("halt_set", 64'(halt_b), 64'd1);
        chk("halt_level", 64'(level_b), 64'd1);
        ifb.in_rec[0] = mk(62, 1'b0);
        ifb.in_rec[1] = mk(63, 1'b0);
        step();
        step();
        ifb.in_valid = '0;
        chk("halt_ignore_level", 64'(level_b), 64'd1);
        chk("halt_no_drop", 64'(drop_b), 64'd0);
        ifb.out_ready = 1'b1;
        wait_empty(1, 10);
        ifb.out_ready = 1'b0;
        chk("halt_sticky", 64'(halt_b), 64'd1);

        rst_b = 1'b1;
        step();
        rst_b = 1'b0;
        chk("b_rst_halted", 64'(halt_b), 64'd0);
        step();

        // Overfill with drops, drain to 5, then reset mid-operation
        for (int c = 0; c < 9; c++) begin
            ifb.in_valid = 2'b11;
            ifb.in_rec[0] = mk(100 + 2 * c, 1'b0);
            ifb.in_rec[1] = mk(101 + 2 * c, 1'b0);
            if (c < 8) begin
                expect_rec(1, 64'(2 * c), 100 + 2 * c);
                expect_rec(1, 64'(2 * c + 1), 101 + 2 * c);
            end
            step();
        end
        ifb.in_valid = '0;
        chk("fill_level", 64'(level_b), 64'd16);
        chk("fill_drop", 64'(drop_b), 64'd2);
        chk("fill_overflow", 64'(ovf_b), 64'd1);
        ifb.out_ready = 1'b1;
        for (int k = 0; k < 11; k++) step();
        ifb.out_ready = 1'b0;
        chk("mid_level", 64'(level_b), 64'd5);
        rst_b = 1'b1;
        #1;
        chk("mid_rst_out_valid", 64'(ifb.out_valid), 64'd0);
        chk("mid_rst_level", 64'(level_b), 64'd0);
        chk("mid_rst_drop", 64'(drop_b), 64'd0);
        chk("mid_rst_overflow", 64'(ovf_b), 64'd0);
        chk("mid_rst_halted", 64'(halt_b), 64'd0);
        chk("mid_rst_out_order", ifb.out_order, 64'd0);
        chk("mid_rst_stale", 64'(exp_q[1].size()), 64'd5);
        exp_q[1].delete();
        step();
        rst_b = 1'b0;
        ifb.in_valid = 2'b10;
        ifb.in_rec[1] = mk(200, 1'b0);
        expect_rec(1, 64'd0, 200);
        ifb.out_ready = 1'b1;
        step();
        ifb.in_valid = '0;
        wait_empty(1, 10);
        ifb.out_ready = 1'b0;

        // Small FIFO: space check ignores same-cycle pop, drops leave order gaps
        ifc.in_valid = 2'b11;
        ifc.in_rec[0] = mk(40, 1'b0);
        ifc.in_rec[1] = mk(41, 1'b0);
        expect_rec(2, 64'd0, 40);
        expect_rec(2, 64'd1, 41);
        step();
        ifc.in_valid = 2'b01;
        ifc.in_rec[0] = mk(42, 1'b0);
        expect_rec(2, 64'd2, 42);
        step();
        chk("c_level_3", 64'(level_c), 64'd3);
        ifc.in_valid = 2'b11;
        ifc.in_rec[0] = mk(43, 1'b0);
        ifc.in_rec[1] = mk(44, 1'b0);
        expect_rec(2, 64'd3, 43);
        ifc.out_ready = 1'b1;
        step();
        ifc.in_valid = '0;
        ifc.out_ready = 1'b0;
        chk("c_level_after_pop", 64'(level_c), 64'd3);
        chk("c_drop_1", 64'(drop_c), 64'd1);
        chk("c_overflow", 64'(ovf_c), 64'd1);
        ifc.in_valid = 2'b01;
        ifc.in_rec[0] = mk(45, 1'b0);
        expect_rec(2, 64'd5, 45);
        step();
        ifc.in_valid = '0;
        chk("c_full", 64'(level_c), 64'd4);
        ifc.out_ready = 1'b1;
        wait_empty(2, 10);
        ifc.out_ready = 1'b0;

        // Drop counter saturation
        for (int c = 0; c < 4; c++) begin
            ifc.in_valid = 2'b11;
            ifc.in_rec[0] = mk(46 + 2 * c, 1'b0);
            ifc.in_rec[1] = mk(47 + 2 * c, 1'b0);
            if (c < 2) begin
                expect_rec(2, 64'(6 + 2 * c), 46 + 2 * c);
                expect_rec(2, 64'(7 + 2 * c), 47 + 2 * c);
            end
            step();
            if (c == 2) chk("c_drop_3", 64'(drop_c), 64'd3);
        end
        ifc.in_valid = '0;
        chk("c_drop_sat", 64'(drop_c), 64'd3);
        ifc.out_ready = 1'b1;
        wait_empty(2, 10);
        ifc.out_ready = 1'b0;

        step();
        step();
        chk("sb_left_a", 64'(exp_q[0].size()), 64'd0);
        chk("sb_left_b", 64'(exp_q[1].size()), 64'd0);
        chk("sb_left_c", 64'(exp_q[2].size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
